// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
// Optional signed-overflow output is enabled with SERIAL_ADD_OVF_EN.
package nibble_serial_adder_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Number of nibble passes needed for a WIDTH-bit operand
    function automatic int unsigned calc_nibbles(input int unsigned width);
        return width / NIBBLE_W;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle for the nibble-serial adder.
// The ovf signal exists only when SERIAL_ADD_OVF_EN is defined.
interface nibble_serial_adder_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S;
    logic             cout;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf;

    modport master (
        output in_valid, A, B, cin, out_ready,
        input  in_ready, out_valid, S, cout, ovf
    );

    modport slave (
        input  in_valid, A, B, cin, out_ready,
        output in_ready, out_valid, S, cout, ovf
    );
`else
    modport master (
        output in_valid, A, B, cin, out_ready,
        input  in_ready, out_valid, S, cout
    );

    modport slave (
        input  in_valid, A, B, cin, out_ready,
        output in_ready, out_valid, S, cout
    );
`endif

endinterface

// File: rtl/nibble_serial_adder_add_stage.sv
// Combinational 4-bit add stage shared by every nibble pass.
module nibble_add_stage
    import nibble_serial_adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] A,
    input  logic [NIBBLE_W-1:0] B,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] S,
    output logic                cout
);

    logic [NIBBLE_W:0] sum;

    assign sum  = (NIBBLE_W+1)'(A) + (NIBBLE_W+1)'(B) + (NIBBLE_W+1)'(cin);
    assign S    = sum[NIBBLE_W-1:0];
    assign cout = sum[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder evaluated one nibble per clock through a single 4-bit stage.
// Define SERIAL_ADD_OVF_EN to add the registered signed-overflow output.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    nibble_serial_adder_if.slave bus
);

    localparam int unsigned     NIBBLES  = calc_nibbles(WIDTH);
    localparam int unsigned     CNT_W    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBBLES - 1);

    localparam logic [1:0] ST_IDLE = 2'(IDLE);
    localparam logic [1:0] ST_ADD  = 2'(ADD);
    localparam logic [1:0] ST_DONE = 2'(DONE);

    logic [1:0]          state_q;
    logic [1:0]          state_d;
    logic [CNT_W-1:0]    nib_cnt;
    logic [WIDTH-1:0]    a_q;
    logic [WIDTH-1:0]    b_q;
    logic [WIDTH-1:0]    s_q;
    logic                carry_q;
    logic                out_valid_q;
    logic                in_ready_c;
    logic                accept_c;
    logic                last_nib_c;
    logic [NIBBLE_W-1:0] stage_s;
    logic                stage_cout;

    assign in_ready_c = (state_q == ST_IDLE) && !rst;
    assign accept_c   = bus.in_valid && in_ready_c;
    assign last_nib_c = (nib_cnt == LAST_NIB);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept_c)      state_d = ST_ADD;
            ST_ADD:  if (last_nib_c)    state_d = ST_DONE;
            ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
            default:                    state_d = ST_IDLE;
        endcase
    end

    nibble_add_stage u_stage (
        .A    (a_q[NIBBLE_W-1:0]),
        .B    (b_q[NIBBLE_W-1:0]),
        .cin  (carry_q),
        .S    (stage_s),
        .cout (stage_cout)
    );

    // Operand/sum shift registers; each stage sum enters at the top of S
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q         <= '0;
            b_q         <= '0;
            s_q         <= '0;
            carry_q     <= 1'b0;
            nib_cnt     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= (state_d == ST_DONE);
            if (accept_c) begin
                a_q     <= bus.A;
                b_q     <= bus.B;
                carry_q <= bus.cin;
                nib_cnt <= '0;
            end else if (state_q == ST_ADD) begin
                a_q     <= a_q >> NIBBLE_W;
                b_q     <= b_q >> NIBBLE_W;
                s_q     <= WIDTH'({stage_s, s_q} >> NIBBLE_W);
                carry_q <= stage_cout;
                nib_cnt <= nib_cnt + CNT_W'(1);
            end
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    logic a_msb_q;
    logic b_msb_q;
    logic ovf_q;

    // Overflow resolves on the final nibble, using the operand sign bits kept at acceptance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept_c) begin
            a_msb_q <= bus.A[WIDTH-1];
            b_msb_q <= bus.B[WIDTH-1];
            ovf_q   <= 1'b0;
        end else if ((state_q == ST_ADD) && last_nib_c) begin
            ovf_q   <= (a_msb_q == b_msb_q) && (stage_s[NIBBLE_W-1] != a_msb_q);
        end
    end

    assign bus.ovf = ovf_q;
`endif

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.S         = s_q;
    assign bus.cout      = carry_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH=16) with a result scoreboard.
module tb_nibble_serial_adder;

    localparam int unsigned WIDTH = 16;

    logic clk = 1'b0;
    logic rst;

    nibble_serial_adder_if #(.WIDTH(WIDTH)) bus ();

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] s;
        logic        cout;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [15:0] s;
        logic        cout;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s timed out (t=%0t)", name, $time);
    endtask

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic c);
        logic [16:0] sum;
        exp_t        e;
        sum    = 17'(a) + 17'(b) + 17'(c);
        e.s    = sum[15:0];
        e.cout = sum[16];
        e.ovf  = (a[15] == b[15]) && (sum[15] != a[15]);
        return e;
    endfunction

    task automatic wait_ready(output bit ok);
        int n = 0;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        ok = bus.in_ready;
        if (!ok) timeout("in_ready_wait");
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!bus.out_valid) timeout("out_valid_wait");
    endtask

    // Present operands, wait for acceptance, then record the expected result
    task automatic accept(input logic [15:0] a, input logic [15:0] b, input logic c, input exp_t e);
        bit ok;
        bus.A        = a;
        bus.B        = b;
        bus.cin      = c;
        bus.in_valid = 1'b1;
        wait_ready(ok);
        if (!ok) begin
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        sb.push_back(e);
        #1;
        bus.in_valid = 1'b0;
    endtask

    vec_t tbl[8];

    initial begin
        int   n;
        int   prev;
        exp_t e;
        logic [15:0] ra, rb;
        logic        rc;

        tbl[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        tbl[1] = '{16'h0FFF, 16'h0000, 1'b1, 16'h1000, 1'b0, 1'b0};
        tbl[2] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        tbl[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        tbl[6] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
        tbl[7] = '{16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0, 1'b0};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b0;

        fork
            forever begin : monitor
                exp_t m;
                @(negedge clk);
                if (!rst && bus.out_valid && bus.out_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_output S=0x%0h (t=%0t)", bus.S, $time);
                    end else begin
                        m = sb.pop_front();
                        check("sb_S", 32'(bus.S), 32'(m.s));
                        check("sb_cout", 32'(bus.cout), 32'(m.cout));
`ifdef SERIAL_ADD_OVF_EN
                        check("sb_ovf", 32'(bus.ovf), 32'(m.ovf));
`endif
                    end
                end
            end
        join_none

        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 0);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_S", 32'(bus.S), 0);
        check("rst_cout", 32'(bus.cout), 0);
        rst = 1'b0;
        #1;
        check("idle_in_ready", 32'(bus.in_ready), 1);

        // Directed vectors with latency measurement
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            accept(tbl[i].a, tbl[i].b, tbl[i].cin, '{tbl[i].s, tbl[i].cout, tbl[i].ovf});
            n = 0;
            do begin
                @(posedge clk);
                #1;
                n++;
            end while (!bus.out_valid && n < 20);
            check("latency", 32'(n), 4);
        end

        // Back-pressure: result held while out_ready is low, in_valid ignored
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        accept(16'h1234, 16'h4321, 1'b0, model(16'h1234, 16'h4321, 1'b0));
        wait_out(n);
        for (int k = 0; k < 3; k++) begin
            bus.in_valid = (k != 1);
            bus.A        = 16'hFFFF;
            bus.B        = 16'hFFFF;
            @(posedge clk);
            #1;
            check("hold_S", 32'(bus.S), 32'h5555);
            check("hold_cout", 32'(bus.cout), 0);
            check("hold_out_valid", 32'(bus.out_valid), 1);
            check("hold_in_ready", 32'(bus.in_ready), 0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release_out_valid", 32'(bus.out_valid), 0);
        check("release_in_ready", 32'(bus.in_ready), 1);
        @(posedge clk);
        #1;
        check("post_hold_idle", 32'(bus.in_ready), 1);

        // Reset in the middle of ADD discards the operation
        accept(16'h5555, 16'h1111, 1'b0, model(16'h5555, 16'h1111, 1'b0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        sb.delete();
        check("midrst_out_valid", 32'(bus.out_valid), 0);
        check("midrst_S", 32'(bus.S), 0);
        check("midrst_cout", 32'(bus.cout), 0);
        check("midrst_in_ready", 32'(bus.in_ready), 0);
`ifdef SERIAL_ADD_OVF_EN
        check("midrst_ovf", 32'(bus.ovf), 0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("postrst_in_ready", 32'(bus.in_ready), 1);
        check("postrst_S", 32'(bus.S), 0);
        accept(16'h0001, 16'h0001, 1'b0, '{16'h0002, 1'b0, 1'b0});
        wait_out(n);
        check("postrst_S_result", 32'(bus.S), 32'h0002);
        @(posedge clk);
        #1;

        // Back-to-back random traffic, fixed initiation interval
        prev = 0;
        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom_range(0, 1));
            e  = model(ra, rb, rc);
            accept(ra, rb, rc, e);
            if (i > 0) check("interval", 32'(cyc - prev), 6);
            prev = cyc;
        end
        wait_out(n);
        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", 32'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
